seg7_scan_decoder: RTL and testbench

//  Receive-side counterpart of the nibble-to-segment encoder. Watches a

---
 rtl/seg7_scan_if.sv | 26 ++
 rtl/seg7_scan_decoder.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bus bundle between a multiplexed common-anode 7-seg driver and the scan decoder.
// The master drives the pads and clr; the slave returns the recovered digit state.
interface seg7_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_vld;
  logic                    upd;
  logic [2:0]              upd_idx;
  logic                    err_bad;
  logic                    err_multi;

  modport master (
    output seg, an, clr,
    input  digits, dp, digit_vld, upd, upd_idx, err_bad, err_multi
  );

  modport slave (
    input  seg, an, clr,
    output digits, dp, digit_vld, upd, upd_idx, err_bad, err_multi
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed common-anode 7-seg bus and recovers each digit's hex nibble and dp.
// A sample is evaluated once per window after it has been stable for STABLE_CYCLES.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic      clk,
  input logic      rst_n,
  seg7_scan_if.slave bus
);

  localparam int unsigned W  = NUM_DIGITS + 8;
  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(STABLE_CYCLES - 1);

  localparam logic [0:0] StSettle = 1'b0;
  localparam logic [0:0] StHeld   = 1'b1;

  logic [W-1:0]            sync1_q, samp_q, samp_prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [0:0]              state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   vld_q, vld_d;
  logic                    upd_q, upd_d;
  logic [2:0]              upd_idx_q, upd_idx_d;
  logic                    err_bad_q, err_bad_d;
  logic                    err_multi_q, err_multi_d;

  logic                  same;
  logic                  eval;
  logic [NUM_DIGITS-1:0] samp_an;
  logic [7:0]            samp_seg;
  logic [3:0]            low_cnt;
  logic [2:0]            low_idx;
  logic                  hit;
  logic [3:0]            nib;

  // Returns {hit, nibble} for an active-low g..a pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = 5'h10;
      7'h79:   seg_decode = 5'h11;
      7'h24:   seg_decode = 5'h12;
      7'h30:   seg_decode = 5'h13;
      7'h19:   seg_decode = 5'h14;
      7'h12:   seg_decode = 5'h15;
      7'h02:   seg_decode = 5'h16;
      7'h78:   seg_decode = 5'h17;
      7'h00:   seg_decode = 5'h18;
      7'h10:   seg_decode = 5'h19;
      7'h08:   seg_decode = 5'h1A;
      7'h03:   seg_decode = 5'h1B;
      7'h46:   seg_decode = 5'h1C;
      7'h21:   seg_decode = 5'h1D;
      7'h06:   seg_decode = 5'h1E;
      7'h0E:   seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  assign samp_an  = samp_q[W-1:8];
  assign samp_seg = samp_q[7:0];
  assign same     = (samp_q == samp_prev_q);
  assign eval     = (state_q == StSettle) && same && (cnt_q == CntMax);
  assign {hit, nib} = seg_decode(samp_seg[6:0]);

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (!samp_an[i]) begin
        low_cnt = low_cnt + 4'd1;
        low_idx = 3'(i);
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSettle: if (eval) state_d = StHeld;
      StHeld:   if (!same) state_d = StSettle;
      default:  state_d = StSettle;
    endcase
  end

  // clr is applied first so an evaluation in the same cycle can set bits back.
  always_comb begin
    digits_d    = digits_q;
    dp_d        = dp_q;
    vld_d       = bus.clr ? '0 : vld_q;
    err_bad_d   = bus.clr ? 1'b0 : err_bad_q;
    err_multi_d = bus.clr ? 1'b0 : err_multi_q;
    upd_d       = 1'b0;
    upd_idx_d   = upd_idx_q;
    if (eval) begin
      if (low_cnt == 4'd1) begin
        if (hit) begin
          for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!samp_an[i]) begin
              digits_d[4*i +: 4] = nib;
              dp_d[i]            = ~samp_seg[7];
              vld_d[i]           = 1'b1;
            end
          end
          upd_d     = 1'b1;
          upd_idx_d = low_idx;
        end else begin
          err_bad_d = 1'b1;
        end
      end else if (low_cnt > 4'd1) begin
        err_multi_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      samp_q      <= '1;
      samp_prev_q <= '1;
      cnt_q       <= '0;
      state_q     <= StSettle;
      digits_q    <= '0;
      dp_q        <= '0;
      vld_q       <= '0;
      upd_q       <= 1'b0;
      upd_idx_q   <= '0;
      err_bad_q   <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      sync1_q     <= {bus.an, bus.seg};
      samp_q      <= sync1_q;
      samp_prev_q <= samp_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      vld_q       <= vld_d;
      upd_q       <= upd_d;
      upd_idx_q   <= upd_idx_d;
      err_bad_q   <= err_bad_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.dp        = dp_q;
  assign bus.digit_vld = vld_q;
  assign bus.upd       = upd_q;
  assign bus.upd_idx   = upd_idx_q;
  assign bus.err_bad   = err_bad_q;
  assign bus.err_multi = err_multi_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: capture latency, scan, glitch rejection,
// error flags with clear, and reset in the middle of a stable window.
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   upd_cnt = 0;

  seg7_scan_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS   (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.upd) upd_cnt <= upd_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.an  = 4'b1110;
    bus.seg = 8'hC0;
    bus.clr = 1'b0;
    #2;
    chk("rst_digits", 32'(bus.digits), 32'h0);
    chk("rst_dp", 32'(bus.dp), 32'h0);
    chk("rst_vld", 32'(bus.digit_vld), 32'h0);
    chk("rst_upd", 32'(bus.upd), 32'h0);
    chk("rst_idx", 32'(bus.upd_idx), 32'h0);
    chk("rst_errs", 32'({bus.err_bad, bus.err_multi}), 32'h0);
    #10;
    rst_n = 1'b1;

    // 1: single digit '0', upd on the 7th edge after the change
    tick(6);
    chk("t1_no_early_upd", 32'(bus.upd), 32'h0);
    tick(1);
    chk("t1_upd", 32'(bus.upd), 32'h1);
    chk("t1_idx", 32'(bus.upd_idx), 32'h0);
    chk("t1_digit0", 32'(bus.digits[3:0]), 32'h0);
    chk("t1_dp", 32'(bus.dp), 32'h0);
    chk("t1_vld", 32'(bus.digit_vld), 32'h1);
    tick(3);
    chk("t1_one_pulse", 32'(upd_cnt), 32'd1);

    // 2: full scan 2,4,6,8 with dp on digit 3
    bus.an = 4'b1110; bus.seg = 8'hA4; tick(8);
    bus.an = 4'b1101; bus.seg = 8'h99; tick(8);
    bus.an = 4'b1011; bus.seg = 8'h82; tick(8);
    bus.an = 4'b0111; bus.seg = 8'h00; tick(8);
    chk("t2_digits", 32'(bus.digits), 32'h8642);
    chk("t2_dp", 32'(bus.dp), 32'h8);
    chk("t2_vld", 32'(bus.digit_vld), 32'hF);
    chk("t2_upd_cnt", 32'(upd_cnt), 32'd5);

    // 3: pattern toggling every 2 cycles is never stable long enough
    bus.an = 4'b1101;
    for (int k = 0; k < 10; k++) begin
      bus.seg = (k % 2 == 0) ? 8'hC0 : 8'hF9;
      tick(2);
    end
    chk("t3_errs", 32'({bus.err_bad, bus.err_multi}), 32'h0);

    // 4: bad pattern, then two digits selected, then clear
    bus.an = 4'b1110; bus.seg = 8'h11; tick(10);
    chk("t3_no_upd", 32'(upd_cnt), 32'd5);
    chk("t3_vld", 32'(bus.digit_vld), 32'hF);
    chk("t4_err_bad", 32'(bus.err_bad), 32'h1);
    chk("t4_err_multi0", 32'(bus.err_multi), 32'h0);
    chk("t4_slot0_kept", 32'(bus.digits), 32'h8642);
    bus.an = 4'b1100; bus.seg = 8'hC0; tick(10);
    chk("t4_err_multi", 32'(bus.err_multi), 32'h1);
    chk("t4_no_write", 32'(bus.digits), 32'h8642);
    chk("t4_upd_cnt", 32'(upd_cnt), 32'd5);
    bus.clr = 1'b1; tick(1);
    bus.clr = 1'b0;
    chk("t4_clr_errs", 32'({bus.err_bad, bus.err_multi}), 32'h0);
    chk("t4_clr_vld", 32'(bus.digit_vld), 32'h0);
    chk("t4_clr_digits", 32'(bus.digits), 32'h8642);
    chk("t4_clr_dp", 32'(bus.dp), 32'h8);

    // 5: blanking, then reset in the middle of a window
    bus.an = 4'b1111; bus.seg = 8'hFF; tick(10);
    chk("t5_blank_upd", 32'(upd_cnt), 32'd5);
    chk("t5_blank_errs", 32'({bus.err_bad, bus.err_multi}), 32'h0);
    bus.an = 4'b1110; bus.seg = 8'hF9; tick(3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_digits", 32'(bus.digits), 32'h0);
    chk("t5_rst_vld", 32'(bus.digit_vld), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("t5_no_early_upd", 32'(bus.upd), 32'h0);
    chk("t5_upd_cnt_early", 32'(upd_cnt), 32'd5);
    tick(1);
    chk("t5_upd", 32'(bus.upd), 32'h1);
    chk("t5_idx", 32'(bus.upd_idx), 32'h0);
    chk("t5_digits", 32'(bus.digits), 32'h0001);
    chk("t5_dp", 32'(bus.dp), 32'h0);
    chk("t5_vld", 32'(bus.digit_vld), 32'h1);
    tick(3);
    chk("t5_upd_cnt", 32'(upd_cnt), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
